// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: fixed-point constants, widths, quadrant code
// and the arctangent table used by the downstream rotation stages.
package cordic_pkg;

    localparam int XW = 17;
    localparam int ZW = 32;

    // Angles are signed Q3.29 radians, gain is signed Q1.15.
    localparam logic signed [31:0] PI_Q329      = 32'sh6487ED51;
    localparam logic signed [31:0] HALF_PI_Q329 = 32'sh3243F6A9;
    localparam logic signed [16:0] K_INIT_Q115  = 17'sh04DBA;

    typedef enum logic [1:0] {
        Q_NONE = 2'b00,
        Q_POS  = 2'b01,
        Q_NEG  = 2'b10
    } quad_t;

    localparam int ATAN_N = 16;

    // atan(2^-i) in Q3.29 for stage i.
    function automatic logic signed [31:0] atan_q329(input int i);
        logic signed [31:0] r;
        case (i)
            0:       r = 32'sh1921FB54;
            1:       r = 32'sh0ED63383;
            2:       r = 32'sh07D6DD7E;
            3:       r = 32'sh03FAB753;
            4:       r = 32'sh01FF55BB;
            5:       r = 32'sh00FFEAAE;
            6:       r = 32'sh007FFD55;
            7:       r = 32'sh003FFFAB;
            8:       r = 32'sh001FFFF5;
            9:       r = 32'sh000FFFFF;
            10:      r = 32'sh00080000;
            11:      r = 32'sh00040000;
            12:      r = 32'sh00020000;
            13:      r = 32'sh00010000;
            14:      r = 32'sh00008000;
            15:      r = 32'sh00004000;
            default: r = 32'sh00000000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cordic_pipe_reg.sv
// One valid/ready register slot. When adv is high the slot takes whatever
// the upstream offers (possibly nothing, which empties it); otherwise it holds.
module cordic_pipe_reg
    import cordic_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    // Slot register: data only changes on a real load so it stays stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (adv) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/cordic_input_stage.sv
// CORDIC front-end: clamps the target angle to +/-pi, folds it into
// [-pi/2, +pi/2] by a quadrant pre-rotation and produces the initial
// (x0, y0, z0, z_sign) vector for stage 0. Two register slots, full back-pressure.
module cordic_input_stage
    import cordic_pkg::*;
#(
    parameter int                       XW     = cordic_pkg::XW,
    parameter int                       ZW     = cordic_pkg::ZW,
    parameter logic signed [XW-1:0]     K_INIT = 17'sh04DBA,
    parameter int                       TAGW   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ZW-1:0]   in_theta,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XW-1:0]   out_x,
    output logic [XW-1:0]   out_y,
    output logic [ZW-1:0]   out_z,
    output logic            out_zsign,
    output logic            out_err,
    output logic [TAGW-1:0] out_tag
);

    localparam int AW = ZW + 2 + 1 + TAGW;
    localparam int BW = XW + ZW + 1 + 1 + TAGW;

    logic signed [ZW-1:0] pi_z;
    logic signed [ZW-1:0] hpi_z;
    assign pi_z  = ZW'(PI_Q329);
    assign hpi_z = ZW'(HALF_PI_Q329);

    logic            a_adv;
    logic            b_adv;
    logic            a_valid;
    logic            b_valid;
    logic [AW-1:0]   a_d;
    logic [AW-1:0]   a_q;
    logic [BW-1:0]   b_d;
    logic [BW-1:0]   b_q;
    logic [TAGW-1:0] tag_cnt;

    assign b_adv    = !b_valid || out_ready;
    assign a_adv    = !a_valid || b_adv;
    assign in_ready = a_adv && !rst;

    logic signed [ZW-1:0] t_in;
    logic                 err_in;
    quad_t                q_in;

    // Clamp to +/-pi and classify the quadrant; exactly +/-pi/2 stays unfolded.
    always_comb begin
        t_in   = $signed(in_theta);
        err_in = 1'b0;
        q_in   = Q_NONE;
        if (t_in > pi_z) begin
            t_in   = pi_z;
            err_in = 1'b1;
        end else if (t_in < -pi_z) begin
            t_in   = -pi_z;
            err_in = 1'b1;
        end
        if (t_in > hpi_z) begin
            q_in = Q_POS;
        end else if (t_in < -hpi_z) begin
            q_in = Q_NEG;
        end
    end

    assign a_d = {t_in, q_in, err_in, tag_cnt};

    // Sample tag counter; wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_cnt <= '0;
        end else if (in_valid && in_ready) begin
            tag_cnt <= tag_cnt + TAGW'(1);
        end
    end

    cordic_pipe_reg #(.W(AW)) u_slot_a (
        .clk       (clk),
        .rst       (rst),
        .adv       (a_adv),
        .in_valid  (in_valid),
        .in_data   (a_d),
        .out_valid (a_valid),
        .out_data  (a_q)
    );

    logic signed [ZW-1:0] a_t;
    quad_t                a_quad;
    logic                 a_err;
    logic [TAGW-1:0]      a_tag;
    assign a_t    = $signed(a_q[AW-1 -: ZW]);
    assign a_quad = quad_t'(a_q[TAGW+1 +: 2]);
    assign a_err  = a_q[TAGW];
    assign a_tag  = a_q[TAGW-1:0];

    logic signed [ZW-1:0] z0;
    logic signed [XW-1:0] x0;

    // Quadrant pre-rotation by +/-pi; a half-turn also flips the sign of x0.
    always_comb begin
        z0 = a_t;
        x0 = K_INIT;
        case (a_quad)
            Q_POS: begin
                z0 = a_t - pi_z;
                x0 = -K_INIT;
            end
            Q_NEG: begin
                z0 = a_t + pi_z;
                x0 = -K_INIT;
            end
            default: begin
                z0 = a_t;
                x0 = K_INIT;
            end
        endcase
    end

    assign b_d = {x0, z0, ~z0[ZW-1], a_err, a_tag};

    cordic_pipe_reg #(.W(BW)) u_slot_b (
        .clk       (clk),
        .rst       (rst),
        .adv       (b_adv),
        .in_valid  (a_valid),
        .in_data   (b_d),
        .out_valid (b_valid),
        .out_data  (b_q)
    );

    assign out_valid = b_valid;
    assign out_x     = b_q[BW-1 -: XW];
    assign out_z     = b_q[TAGW+2 +: ZW];
    assign out_zsign = b_q[TAGW+1];
    assign out_err   = b_q[TAGW];
    assign out_tag   = b_q[TAGW-1:0];
    assign out_y     = '0;

endmodule

// File: tb/tb_cordic_input_stage.sv
// Directed-vector bench for cordic_input_stage plus streaming, back-pressure
// and mid-flight reset sequences.
module tb_cordic_input_stage;

    localparam int XW   = 17;
    localparam int ZW   = 32;
    localparam int TAGW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [ZW-1:0]   in_theta;
    logic            out_valid;
    logic            out_ready;
    logic [XW-1:0]   out_x;
    logic [XW-1:0]   out_y;
    logic [ZW-1:0]   out_z;
    logic            out_zsign;
    logic            out_err;
    logic [TAGW-1:0] out_tag;

    always #5 clk = ~clk;

    cordic_input_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_theta  (in_theta),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_z     (out_z),
        .out_zsign (out_zsign),
        .out_err   (out_err),
        .out_tag   (out_tag)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] theta;
        logic [16:0] x;
        logic [31:0] z;
        logic        zsign;
        logic        err;
    } vec_t;

    typedef struct {
        logic [16:0] x;
        logic [31:0] z;
        logic        zsign;
        logic        err;
        logic [7:0]  tag;
    } exp_t;

    vec_t       vecs[12];
    logic [7:0] tag_exp;
    exp_t       q[$];

    // Reference: clamp and fold using wide integer arithmetic.
    function automatic exp_t model(input logic [31:0] th, input logic [7:0] tag);
        exp_t   m;
        longint t, pi, hp, z;
        t  = longint'($signed(th));
        pi = longint'(32'sh6487ED51);
        hp = longint'(32'sh3243F6A9);
        m.err = 1'b0;
        if (t > pi) begin t = pi; m.err = 1'b1; end
        if (t < -pi) begin t = -pi; m.err = 1'b1; end
        m.x = 17'h04DBA;
        if (t > hp) begin
            z = t - pi; m.x = 17'h1B246;
        end else if (t < -hp) begin
            z = t + pi; m.x = 17'h1B246;
        end else begin
            z = t;
        end
        m.z     = z[31:0];
        m.zsign = (z >= 0);
        m.tag   = tag;
        return m;
    endfunction

    // Single isolated sample with out_ready high; starts and ends 1 ns after a rising edge.
    task automatic apply_vec(input vec_t v);
        int lat;
        check({v.name, "_in_ready"}, in_ready, 1);
        in_theta = v.theta;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) begin lat = k; break; end
        end
        // valid after edge N+1, consumed at edge N+2
        check({v.name, "_latency"}, lat, 1);
        check({v.name, "_x"}, out_x, v.x);
        check({v.name, "_y"}, out_y, 0);
        check({v.name, "_z"}, out_z, v.z);
        check({v.name, "_zsign"}, out_zsign, v.zsign);
        check({v.name, "_err"}, out_err, v.err);
        check({v.name, "_tag"}, out_tag, tag_exp);
        tag_exp++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic acc, cons;
        int   sent;
        exp_t e;

        vecs[0]  = '{"zero",      32'h00000000, 17'h04DBA, 32'h00000000, 1'b1, 1'b0};
        vecs[1]  = '{"3pi_4",     32'h4B65EE15, 17'h1B246, 32'hE6DE00C4, 1'b0, 1'b0};
        vecs[2]  = '{"half_pi",   32'h3243F6A9, 17'h04DBA, 32'h3243F6A9, 1'b1, 1'b0};
        vecs[3]  = '{"above_pi",  32'h70000000, 17'h1B246, 32'h00000000, 1'b1, 1'b1};
        vecs[4]  = '{"below_npi", 32'h90000000, 17'h1B246, 32'h00000000, 1'b1, 1'b1};
        vecs[5]  = '{"neg_hpi",   32'hCDBC0957, 17'h04DBA, 32'hCDBC0957, 1'b0, 1'b0};
        vecs[6]  = '{"hpi_p1",    32'h3243F6AA, 17'h1B246, 32'hCDBC0959, 1'b0, 1'b0};
        vecs[7]  = '{"pi_exact",  32'h6487ED51, 17'h1B246, 32'h00000000, 1'b1, 1'b0};
        vecs[8]  = '{"npi_exact", 32'h9B7812AF, 17'h1B246, 32'h00000000, 1'b1, 1'b0};
        vecs[9]  = '{"npi_m1",    32'h9B7812AE, 17'h1B246, 32'h00000000, 1'b1, 1'b1};
        vecs[10] = '{"neg_two",   32'hC0000000, 17'h1B246, 32'h2487ED51, 1'b1, 1'b0};
        vecs[11] = '{"half",      32'h10000000, 17'h04DBA, 32'h10000000, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_theta = '0; out_ready = 1'b1;
        @(posedge clk);
        #1 check("rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", {out_x, out_y, out_z, out_zsign, out_err, out_tag}, 0);
        rst = 1'b0;
        #1 check("post_rst_in_ready", in_ready, 1);

        tag_exp = 8'h00;
        for (int i = 0; i < 12; i++) apply_vec(vecs[i]);

        // Random stream with random back-pressure against a scoreboard.
        sent = 0;
        in_valid  = 1'b1;
        in_theta  = $urandom();
        out_ready = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 4000 && !(sent == 300 && q.size() == 0); cyc++) begin
            @(negedge clk);
            acc  = in_valid && in_ready;
            cons = out_valid && out_ready;
            check("stream_in_ready", in_ready, (q.size() < 2) || out_ready);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("stream_spurious_valid", out_valid, 0);
                end else begin
                    e = q[0];
                    check("stream_data", {out_x, out_y, out_z, out_zsign, out_err, out_tag},
                          {e.x, 17'h0, e.z, e.zsign, e.err, e.tag});
                end
            end
            @(posedge clk);
            if (cons && q.size() > 0) void'(q.pop_front());
            if (acc) begin
                q.push_back(model(in_theta, tag_exp));
                tag_exp++;
                sent++;
            end
            #1;
            if (acc) in_theta = $urandom();
            in_valid  = (sent < 300);
            out_ready = 1'($urandom_range(0, 1));
        end
        check("stream_sent", sent, 300);
        check("stream_drained", q.size(), 0);

        // Two samples in flight, then a one-cycle reset.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_theta  = 32'h10000000;
        @(posedge clk);
        #1 in_theta = 32'h20000000;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("full_out_valid", out_valid, 1);
        check("full_in_ready", in_ready, 0);
        out_ready = 1'b1;
        #1 check("unstall_in_ready", in_ready, 1);
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("flush_out_valid", out_valid, 0);
            check("flush_out_tag", out_tag, 0);
        end
        @(posedge clk);
        #1;
        tag_exp = 8'h00;
        apply_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
